// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Arbitrates access to the SDRAM memory_controller that holds the 128 KB VDP
//   VRAM. Three sources compete for it: the VDP pixel/command port, an auxiliary
//   port (loader/debug/DMA) and an internal auto-refresh scheduler. Only one
//   transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> ACK -> IDLE.
//
//   Ports
//     clk, reset            controller clock, synchronous active-high reset
//     vdp_req/we/addr/din   VDP request (level, held until vdp_ack)
//     vdp_dout, vdp_ack     VDP read byte and one-cycle completion strobe
//     aux_req/we/addr/din   auxiliary request (level, held until aux_ack)
//     aux_dout, aux_ack     auxiliary read byte and one-cycle completion strobe
//     refresh_slot          VDP idle window in which a refresh is cheap
//     mc_read/write/refresh one-cycle command pulses to memory_controller
//     mc_addr/din/wdm       command operands, stable from ISSUE to WAIT_DONE
//     mc_dout, mc_busy      read data and busy flag from memory_controller
//     err                   sticky busy-timeout flag
//
//   Optional feature macro: VRAM_ARB_TIMEOUT_EN
//     Defined:   WAIT_START gives up after BUSY_TIMEOUT cycles without mc_busy,
//                sets err, and acks (reads return 8'hFF).
//     Undefined: WAIT_START waits indefinitely and err is tied 0.
module vram_arbiter #(
  parameter int REFRESH_INTERVAL = 840,
  parameter int REFRESH_URGENT   = 3,
  parameter int AUX_MAX_WAIT     = 64
`ifdef VRAM_ARB_TIMEOUT_EN
  , parameter int BUSY_TIMEOUT   = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vdp_req,
  input  logic        vdp_we,
  input  logic [16:0] vdp_addr,
  input  logic [7:0]  vdp_din,
  output logic [7:0]  vdp_dout,
  output logic        vdp_ack,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [16:0] aux_addr,
  input  logic [7:0]  aux_din,
  output logic [7:0]  aux_dout,
  output logic        aux_ack,
  input  logic        refresh_slot,
  output logic        mc_read,
  output logic        mc_write,
  output logic        mc_refresh,
  output logic [20:0] mc_addr,
  output logic [15:0] mc_din,
  output logic [1:0]  mc_wdm,
  input  logic [15:0] mc_dout,
  input  logic        mc_busy,
  output logic        err
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_ACK        = 3'd4;

  localparam logic [1:0] SRC_VDP = 2'd0;
  localparam logic [1:0] SRC_AUX = 2'd1;
  localparam logic [1:0] SRC_REF = 2'd2;

  localparam int RC_W = $clog2(REFRESH_INTERVAL);
  localparam int AW_W = $clog2(AUX_MAX_WAIT + 1);
  localparam logic [RC_W-1:0] RC_RELOAD = RC_W'(REFRESH_INTERVAL - 1);
  localparam logic [AW_W-1:0] AW_MAX    = AW_W'(AUX_MAX_WAIT);
  localparam logic [2:0]      URGENT    = 3'(REFRESH_URGENT);

  logic [2:0]      state_q, state_d;
  logic [1:0]      src_q, src_d;
  logic            we_q, we_d;
  logic [16:0]     addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic [7:0]      vdp_dout_q, vdp_dout_d;
  logic [7:0]      aux_dout_q, aux_dout_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [2:0]      credits_q, credits_d;
  logic [AW_W-1:0] await_q, await_d;

  logic take_ref, take_vdp, take_aux;
  logic aux_starved, credit_add, credit_use, aux_active, bus_en;
  logic [7:0] rd_byte;

`ifdef VRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  assign aux_starved = aux_req && (await_q == AW_MAX);
  assign rd_byte     = addr_q[16] ? mc_dout[15:8] : mc_dout[7:0];
  assign aux_active  = (state_q != S_IDLE) && (src_q == SRC_AUX);

  // Fixed-priority grant; nothing is granted while the controller is busy.
  always_comb begin
    take_ref = 1'b0;
    take_vdp = 1'b0;
    take_aux = 1'b0;
    if (state_q == S_IDLE && !mc_busy) begin
      if (credits_q >= URGENT)                      take_ref = 1'b1;
      else if (aux_starved)                         take_aux = 1'b1;
      else if (vdp_req)                             take_vdp = 1'b1;
      else if (credits_q != 3'd0 && refresh_slot)   take_ref = 1'b1;
      else if (aux_req)                             take_aux = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    vdp_dout_d = vdp_dout_q;
    aux_dout_d = aux_dout_q;
`ifdef VRAM_ARB_TIMEOUT_EN
    err_d      = err_q;
    tmo_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (take_ref) begin
          src_d   = SRC_REF;
          we_d    = 1'b0;
          addr_d  = '0;
          din_d   = '0;
          state_d = S_ISSUE;
        end else if (take_aux) begin
          src_d   = SRC_AUX;
          we_d    = aux_we;
          addr_d  = aux_addr;
          din_d   = aux_din;
          state_d = S_ISSUE;
        end else if (take_vdp) begin
          src_d   = SRC_VDP;
          we_d    = vdp_we;
          addr_d  = vdp_addr;
          din_d   = vdp_din;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (mc_busy) begin
          state_d = S_WAIT_DONE;
        end
`ifdef VRAM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          // Controller never acknowledged the command: flag it and release
          // the requester with an all-ones read byte.
          err_d   = 1'b1;
          state_d = S_ACK;
          if (!we_q && src_q == SRC_VDP) vdp_dout_d = 8'hFF;
          if (!we_q && src_q == SRC_AUX) aux_dout_d = 8'hFF;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (!mc_busy) begin
          state_d = S_ACK;
          if (!we_q && src_q == SRC_VDP) vdp_dout_d = rd_byte;
          if (!we_q && src_q == SRC_AUX) aux_dout_d = rd_byte;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Refresh credits: a new credit and a completed refresh in the same cycle
  // cancel out.
  assign credit_add = (rcnt_q == '0);
  assign credit_use = (state_q == S_ACK) && (src_q == SRC_REF);

  always_comb begin
    rcnt_d    = credit_add ? RC_RELOAD : rcnt_q - 1'b1;
    credits_d = credits_q;
    if (credit_add && !credit_use && credits_q != 3'd7)    credits_d = credits_q + 3'd1;
    else if (!credit_add && credit_use && credits_q != 3'd0) credits_d = credits_q - 3'd1;
  end

  // Aux starvation counter: frozen while aux owns the controller.
  always_comb begin
    await_d = await_q;
    if (take_aux)                                   await_d = '0;
    else if (aux_req && !aux_active && await_q != AW_MAX) await_d = await_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= SRC_VDP;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      vdp_dout_q <= '0;
      aux_dout_q <= '0;
      rcnt_q     <= RC_RELOAD;
      credits_q  <= '0;
      await_q    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      vdp_dout_q <= vdp_dout_d;
      aux_dout_q <= aux_dout_d;
      rcnt_q     <= rcnt_d;
      credits_q  <= credits_d;
      await_q    <= await_d;
    end
  end

`ifdef VRAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Operands are only presented while a transaction is in flight so that the
  // bus reads all-zero when idle or in reset.
  assign bus_en     = (state_q == S_ISSUE) || (state_q == S_WAIT_START) ||
                      (state_q == S_WAIT_DONE);
  assign mc_read    = (state_q == S_ISSUE) && (src_q != SRC_REF) && !we_q;
  assign mc_write   = (state_q == S_ISSUE) && (src_q != SRC_REF) && we_q;
  assign mc_refresh = (state_q == S_ISSUE) && (src_q == SRC_REF);
  assign mc_addr    = bus_en ? {5'b0, addr_q[15:0]} : 21'd0;
  assign mc_din     = bus_en ? {din_q, din_q} : 16'd0;
  assign mc_wdm     = bus_en ? {~addr_q[16], addr_q[16]} : 2'b00;
  assign vdp_ack    = (state_q == S_ACK) && (src_q == SRC_VDP);
  assign aux_ack    = (state_q == S_ACK) && (src_q == SRC_AUX);
  assign vdp_dout   = vdp_dout_q;
  assign aux_dout   = aux_dout_q;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences the shared SDRAM memory_controller that holds the 128 KB VDP VRAM.
- Arbitrates between three sources: the VDP pixel/command port, an auxiliary port (loader/debug/DMA), and an internal auto-refresh scheduler.
- Replaces the ad-hoc gating of read/write/refresh from VideoDLClk/VideoDHClk with an explicit one-transaction-at-a-time state machine.
- Sits between VDP PRAM* signals and memory_controller; runs in the SDRAM controller clock domain.

Parameters:
REFRESH_INTERVAL, 840, clk cycles between refresh credits (≈7.8 us at 108 MHz)
REFRESH_URGENT, 3, pending-credit count at which refresh pre-empts everything
AUX_MAX_WAIT, 64, cycles aux may wait before it gains priority over VDP
BUSY_TIMEOUT, 16, cycles allowed for mc_busy to rise after a command (optional feature only)

Ports:
clk  in  1  controller clock (same as memory_controller clk)
reset  in  1  synchronous, active-high
vdp_req  in  1  VDP access request, level, held until vdp_ack
vdp_we  in  1  1=write, 0=read
vdp_addr  in  17  VDP byte address; bit16 selects byte lane
vdp_din  in  8  VDP write data
vdp_dout  out  8  VDP read data, valid with vdp_ack
vdp_ack  out  1  one-cycle completion strobe
aux_req  in  1  aux request, level, held until aux_ack
aux_we  in  1  1=write
aux_addr  in  17  aux byte address
aux_din  in  8  aux write data
aux_dout  out  8  aux read data, valid with aux_ack
aux_ack  out  1  one-cycle completion strobe
refresh_slot  in  1  VDP idle window (both DL/DH clocks low)
mc_read  out  1  read command pulse to memory_controller
mc_write  out  1  write command pulse
mc_refresh  out  1  refresh command pulse
mc_addr  out  21  {5'b0, addr[15:0]}
mc_din  out  16  {data, data}
mc_wdm  out  2  {~addr[16], addr[16]}
mc_dout  in  16  read data from memory_controller
mc_busy  in  1  controller busy
err  out  1  sticky timeout flag (0 when optional feature is absent)

Behaviour:
- Reset: all outputs 0, state IDLE, pending refresh credits 0, refresh counter reloaded to REFRESH_INTERVAL-1, aux wait counter 0. Reset asserted mid-transaction aborts it; no ack is issued.
- Refresh counter decrements every cycle. At 0 it reloads and adds one credit (3-bit counter, saturates at 7). A credit added in the same cycle a refresh completes yields a net change of 0.
- Aux wait counter increments while aux_req=1 and aux is not granted, saturates at AUX_MAX_WAIT, and clears on aux grant.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, ACK.
- IDLE grants only when mc_busy=0. Priority, highest first:
  1. credits ≥ REFRESH_URGENT
  2. aux starved (wait = AUX_MAX_WAIT, aux_req=1)
  3. vdp_req
  4. credits > 0 and refresh_slot=1
  5. aux_req
- Grant latches source, we, addr and din, then goes to ISSUE.
- ISSUE: exactly one cycle of mc_read, mc_write or mc_refresh. mc_addr, mc_din and mc_wdm are driven from the latched values and held stable from ISSUE through WAIT_DONE. Next state is WAIT_START.
- WAIT_START: wait for mc_busy=1, then WAIT_DONE.
- WAIT_DONE: on mc_busy=0, capture the read byte (addr16=0 → mc_dout[7:0]; addr16=1 → mc_dout[15:8]), then go to ACK.
- ACK: one cycle of vdp_ack or aux_ack with dout valid; a refresh decrements credits instead. Return to IDLE.
- Latency, no contention: command at grant+1, ack 1 cycle after mc_busy falls.
- dout holds its value until the next read ack for that port.
- A requester may drop req the cycle after ack. A req still high in IDLE is treated as a new request.
- Writes to the 17-bit space wrap naturally; there is no out-of-range condition.

Optional Feature:
VRAM_ARB_TIMEOUT_EN
- Defined: if WAIT_START lasts BUSY_TIMEOUT cycles without mc_busy, set err (sticky until reset) and go to ACK. A read returns 8'hFF. The refresh credit is still consumed.
- Undefined: WAIT_START waits indefinitely and err is tied 0.

Test Plan:
1. VDP write addr=17'h10123, din=8'hA5, mc_busy high for 4 cycles → mc_write pulse 1 cycle, mc_addr=21'h00123, mc_din=16'hA5A5, mc_wdm=2'b01, single vdp_ack after busy falls.
2. VDP read addr=17'h00040, mc_dout=16'h3C7E → vdp_dout=8'h7E. Repeat with addr16=1 → 8'h3C.
3. vdp_req held continuously, refresh_slot=0, sim 3×REFRESH_INTERVAL → urgent mc_refresh issued when credits reach 3, between VDP transactions. Credits return to 2.
4. vdp_req and aux_req both held → VDP served until aux wait hits 64, then one aux transaction, then VDP resumes.
5. credits=1, refresh_slot pulsed with no requests → one mc_refresh, credits 0, no ack on either port.
6. Reset asserted during WAIT_DONE → next cycle all outputs 0, no ack. With VRAM_ARB_TIMEOUT_EN and mc_busy stuck 0 → err=1 after 16 cycles and vdp_dout=8'hFF.
